// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter slice.
//   arb_state_e : burst sequencer states (IDLE, ADDR, DRAIN, TURN)
//   NR_DEF, BW_DEF, RDLAT_DEF : default requester count, burst-length
//                               field width and memory read latency
//   BUS_W       : shared data-bus width (fixed-point word width)
//   idx_w()     : width of an index into n requesters (at least 1)
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DRAIN = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  localparam int unsigned NR_DEF    = 4;
  localparam int unsigned BW_DEF    = 8;
  localparam int unsigned RDLAT_DEF = 1;

  localparam int unsigned BUS_W = 16;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector, bit i = requester i
//   ptr     : highest-priority requester index
//   win_oh  : one-hot winner (first set req at or after ptr, wrapping)
//   win_idx : winner index
//   any     : at least one request present
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NR = NR_DEF
) (
  input  logic [NR-1:0]         req,
  input  logic [idx_w(NR)-1:0]  ptr,
  output logic [NR-1:0]         win_oh,
  output logic [idx_w(NR)-1:0]  win_idx,
  output logic                  any
);

  localparam int unsigned IW = idx_w(NR);

  int unsigned       j;
  logic [IW-1:0]     jj;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    jj      = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      j = 32'(ptr) + i;
      if (j >= NR) j = j - NR;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        win_oh[jj] = 1'b1;
        win_idx    = jj;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared tri-state data bus.
// Each burst: L address cycles (grant), RDLAT drain cycles, then one
// turnaround cycle with every enable low, so two drivers never overlap.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   req   : level requests, bit i = requester i
//   len   : burst length per requester, field i = len[i*BW +: BW]
//   flush : synchronous abort of the current burst
//   grant : one-hot address-phase enable
//   drv   : one-hot bus drive enable (grant delayed RDLAT cycles)
//   beat  : bus carries valid data (|drv)
//   done  : pulse on the last drive cycle of a burst
//   busy  : sequencer not idle
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NR    = NR_DEF,
  parameter int unsigned BW    = BW_DEF,
  parameter int unsigned RDLAT = RDLAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req,
  input  logic [NR*BW-1:0] len,
  input  logic             flush,
  output logic [NR-1:0]    grant,
  output logic [NR-1:0]    drv,
  output logic             beat,
  output logic [NR-1:0]    done,
  output logic             busy
);

  localparam int unsigned IW = idx_w(NR);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] w_q, w_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          zl_q, zl_d;
  logic [NR-1:0] grant_q, grant_d;
  logic          glast_q, glast_d;
  logic [NR-1:0] zl_done_q, zl_done_d;

  logic [NR-1:0] pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [BW-1:0] pick_len;
  logic [NR-1:0] w_oh;
  logic [IW-1:0] ptr_nxt;
  logic          launch;
  logic          flush_act;
  logic [NR-1:0] drv_w;
  logic          dlast_w;

  rr_pick #(.NR(NR)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_len = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (pick_idx == IW'(i)) pick_len = len[i*BW +: BW];
    end
  end

  always_comb begin
    w_oh       = '0;
    w_oh[w_q]  = 1'b1;
    ptr_nxt    = (w_q == IW'(NR - 1)) ? '0 : w_q + IW'(1);
    launch     = ((state_q == IDLE) || (state_q == TURN)) && pick_any;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    zl_d      = zl_q;
    grant_d   = '0;
    glast_d   = 1'b0;
    zl_done_d = '0;
    flush_act = 1'b0;

    unique case (state_q)
      IDLE: ;
      ADDR: begin
        if (flush) begin
          state_d   = TURN;
          ptr_d     = ptr_nxt;
          flush_act = 1'b1;
        end else if (zl_q || (cnt_q == '0)) begin
          // A zero-length burst skips DRAIN: nothing was put in flight.
          if (zl_q || (RDLAT == 0)) begin
            state_d = TURN;
            ptr_d   = ptr_nxt;
          end else begin
            state_d = DRAIN;
            cnt_d   = BW'(RDLAT - 1);
          end
        end else begin
          cnt_d   = cnt_q - BW'(1);
          grant_d = w_oh;
          glast_d = (cnt_q == BW'(1));
        end
      end
      DRAIN: begin
        if (flush || (cnt_q == '0)) begin
          state_d   = TURN;
          ptr_d     = ptr_nxt;
          flush_act = flush;
        end else begin
          cnt_d = cnt_q - BW'(1);
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Arbitration is shared by IDLE and TURN; in TURN ptr_q already
    // points past the requester just served.
    if (launch) begin
      state_d = ADDR;
      w_d     = pick_idx;
      zl_d    = (pick_len == '0);
      if (pick_len == '0) begin
        cnt_d     = '0;
        zl_done_d = pick_oh;
      end else begin
        cnt_d   = pick_len - BW'(1);
        grant_d = pick_oh;
        glast_d = (pick_len == BW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      zl_q      <= 1'b0;
      grant_q   <= '0;
      glast_q   <= 1'b0;
      zl_done_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      zl_q      <= zl_d;
      grant_q   <= grant_d;
      glast_q   <= glast_d;
      zl_done_q <= zl_done_d;
    end
  end

  // drv pipeline carries a "last beat" flag alongside grant so done
  // lines up with the final drive cycle; flush empties both.
  if (RDLAT == 0) begin : g_nolat
    assign drv_w   = grant_q;
    assign dlast_w = glast_q;
  end else begin : g_lat
    logic [NR-1:0]    dpipe_q [RDLAT];
    logic [NR-1:0]    dpipe_d [RDLAT];
    logic [RDLAT-1:0] lpipe_q, lpipe_d;

    always_comb begin
      for (int unsigned i = 0; i < RDLAT; i++) begin
        dpipe_d[i] = '0;
      end
      lpipe_d = '0;
      if (!flush_act) begin
        dpipe_d[0] = grant_q;
        lpipe_d[0] = glast_q;
        for (int unsigned i = 1; i < RDLAT; i++) begin
          dpipe_d[i] = dpipe_q[i-1];
          lpipe_d[i] = lpipe_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < RDLAT; i++) begin
          dpipe_q[i] <= '0;
        end
        lpipe_q <= '0;
      end else begin
        for (int unsigned i = 0; i < RDLAT; i++) begin
          dpipe_q[i] <= dpipe_d[i];
        end
        lpipe_q <= lpipe_d;
      end
    end

    assign drv_w   = dpipe_q[RDLAT-1];
    assign dlast_w = lpipe_q[RDLAT-1];
  end

  assign grant = grant_q;
  assign drv   = drv_w;
  assign beat  = |drv_w;
  assign done  = zl_done_q | (dlast_w ? drv_w : '0);
  assign busy  = (state_q != IDLE);

endmodule
